// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS phase engine: phase-split widths, config
// select encodings and the dither LFSR constants.
package ddfs_pkg;

  localparam int OCT_W = 3;

  localparam logic CFG_SEL_FTW  = 1'b0;
  localparam logic CFG_SEL_POFF = 1'b1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int rem_w(input int n);
    return n - OCT_W;
  endfunction

  function automatic int rot_w(input int n, input int l);
    return n - OCT_W - l;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/phase_fold.sv
// Combinational octant transform: truncated phase -> octant, LUT address and
// rotation residue, with odd octants mirrored.
module phase_fold
  import ddfs_pkg::*;
#(
  parameter int N = 17,
  parameter int L = 6
) (
  input  logic [N-1:0]          p,
  output logic [2:0]            phi_r,
  output logic [L-1:0]          phi_lut,
  output logic [rot_w(N,L)-1:0] phi_rot
);

  localparam int REM_W = rem_w(N);
  localparam int ROT_W = rot_w(N, L);

  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] f;

  assign rem = p[REM_W-1:0];
  // Odd octants run backwards through the quarter-wave table.
  assign f       = p[N-3] ? ~rem : rem;
  assign phi_r   = p[N-1 -: 3];
  assign phi_lut = f[REM_W-1 -: L];
  assign phi_rot = f[ROT_W-1:0];

endmodule

// File: rtl/ddfs_phase_engine.sv
// Time-multiplexed multi-channel phase accumulator with octant transform.
// Optional PT_DITHER_EN adds LFSR dither below the truncation point.
module ddfs_phase_engine
  import ddfs_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int N     = 17,
  parameter int L     = 6,
  parameter int CH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    cfg_wr,
  input  logic                    cfg_sel,
  input  logic [$clog2(CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]        cfg_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(CH)-1:0]   out_ch,
  output logic [2:0]              phi_r,
  output logic [L-1:0]            phi_lut,
  output logic [rot_w(N,L)-1:0]   phi_rot
);

  localparam int CW    = $clog2(CH);
  localparam int ROT_W = rot_w(N, L);

  logic [ACC_W-1:0] acc  [CH];
  logic [ACC_W-1:0] ftw  [CH];
  logic [ACC_W-1:0] poff [CH];

  logic [CW-1:0]    sc;
  logic [CW-1:0]    s1_ch;
  logic [ACC_W-1:0] s1_phase;
  logic             s1_v;

  logic             stall;
  logic             issue;
  logic [ACC_W-1:0] dither;
  logic [ACC_W-1:0] sample_phase;

  logic [2:0]       fold_r;
  logic [L-1:0]     fold_lut;
  logic [ROT_W-1:0] fold_rot;

  assign stall = out_valid & ~out_ready;
  assign issue = en & ~stall & ~sync;

`ifdef PT_DITHER_EN
  localparam int DW = (ACC_W - N < 16) ? (ACC_W - N) : 16;
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr <= LFSR_SEED;
    else if (issue) lfsr <= lfsr_next(lfsr);
  end

  assign dither = {{(ACC_W-DW){1'b0}}, lfsr[DW-1:0]};
`else
  assign dither = '0;
`endif

  // Sample uses the pre-update accumulator so the first sample equals poff.
  assign sample_phase = acc[sc] + poff[sc] + dither;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        ftw[i]  <= '0;
        poff[i] <= '0;
      end
    end else if (cfg_wr) begin
      if (cfg_sel == CFG_SEL_POFF) poff[cfg_ch] <= cfg_data;
      else                         ftw[cfg_ch]  <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else if (sync) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else if (issue) begin
      acc[sc] <= acc[sc] + ftw[sc];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc       <= '0;
      s1_ch    <= '0;
      s1_phase <= '0;
      s1_v     <= 1'b0;
    end else if (sync) begin
      sc   <= '0;
      s1_v <= 1'b0;
    end else if (issue) begin
      s1_phase <= sample_phase;
      s1_ch    <= sc;
      sc       <= sc + CW'(1);
      s1_v     <= 1'b1;
    end else if (!stall) begin
      s1_v <= 1'b0;
    end
  end

  phase_fold #(.N(N), .L(L)) u_fold (
    .p       (s1_phase[ACC_W-1 -: N]),
    .phi_r   (fold_r),
    .phi_lut (fold_lut),
    .phi_rot (fold_rot)
  );

  // Sync wins over stall: a pending output is dropped, not delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      phi_r     <= '0;
      phi_lut   <= '0;
      phi_rot   <= '0;
    end else if (sync) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_v;
      out_ch    <= s1_ch;
      phi_r     <= fold_r;
      phi_lut   <= fold_lut;
      phi_rot   <= fold_rot;
    end
  end

endmodule

// File: tb/tb_ddfs_phase_engine.sv
// Self-checking bench for ddfs_phase_engine: table of phase-offset vectors
// plus directed round-robin, sweep, stall, sync and reset sequences.
module tb_ddfs_phase_engine;
  import ddfs_pkg::*;

  localparam int ACC_W = 32;
  localparam int N     = 17;
  localparam int L     = 6;
  localparam int CH    = 4;
  localparam int ROT_W = N - 3 - L;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sync;
  logic             cfg_wr;
  logic             cfg_sel;
  logic [1:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_ch;
  logic [2:0]       phi_r;
  logic [L-1:0]     phi_lut;
  logic [ROT_W-1:0] phi_rot;

  int checks = 0;
  int errors = 0;

  ddfs_phase_engine #(.ACC_W(ACC_W), .N(N), .L(L), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_ch    (cfg_ch),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .phi_r     (phi_r),
    .phi_lut   (phi_lut),
    .phi_rot   (phi_rot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] poff;
    logic [2:0]  r;
    logic [5:0]  lut;
    logic [7:0]  rot;
  } vec_t;

  vec_t vecs [7];

  logic [1:0]  sCh;
  logic [2:0]  sR;
  logic [5:0]  sLut;
  logic [7:0]  sRot;
  logic        sOk;
  int          nextCh;
  int          nextOct;
  logic [18:0] frozen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic writeCfg(input logic sel, input logic [1:0] ch, input logic [31:0] data);
    cfg_wr   = 1'b1;
    cfg_sel  = sel;
    cfg_ch   = ch;
    cfg_data = data;
    @(negedge clk);
    cfg_wr   = 1'b0;
  endtask

  task automatic syncPulse();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  // Returns the next sample that will be accepted on the following edge.
  task automatic getSample();
    sOk = 1'b0;
    for (int i = 0; i < 20 && !sOk; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        sOk  = 1'b1;
        sCh  = out_ch;
        sR   = phi_r;
        sLut = phi_lut;
        sRot = phi_rot;
      end
    end
    if (!sOk) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_timeout: got no valid sample in 20 cycles, expected one");
    end
  endtask

  task automatic checkStream();
    checkOutput("stream_ch", 32'(sCh), 32'(nextCh));
    if (nextCh == 0) begin
      checkOutput("ch0_octant", 32'(sR), 32'(nextOct));
      nextOct = (nextOct + 1) % 8;
    end
    nextCh = (nextCh + 1) % CH;
  endtask

  task automatic applyStimulus(input vec_t v);
    en = 1'b0;
    writeCfg(CFG_SEL_POFF, 2'(v.ch), v.poff);
    syncPulse();
    en = 1'b1;
    for (int k = 0; k <= v.ch; k++) getSample();
    checkOutput("vec_ch",  32'(sCh),  32'(v.ch));
    checkOutput("vec_r",   32'(sR),   32'(v.r));
    checkOutput("vec_lut", 32'(sLut), 32'(v.lut));
    checkOutput("vec_rot", 32'(sRot), 32'(v.rot));
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 32'h80000000, 3'd4, 6'd0,  8'h00};
    vecs[1] = '{1, 32'hE0000000, 3'd7, 6'd63, 8'hFF};
    vecs[2] = '{2, 32'hABCD1234, 3'd5, 6'd40, 8'h65};
    vecs[3] = '{3, 32'h40000000, 3'd2, 6'd0,  8'h00};
    vecs[4] = '{3, 32'h30000000, 3'd1, 6'd31, 8'hFF};
    vecs[5] = '{0, 32'h00008000, 3'd0, 6'd0,  8'h01};
    vecs[6] = '{0, 32'h00007FFF, 3'd0, 6'd0,  8'h00};

    rst_n     = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    cfg_wr    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_ch    = 2'd0;
    cfg_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ch",    32'(out_ch),    32'd0);
    checkOutput("rst_r",     32'(phi_r),     32'd0);
    checkOutput("rst_lut",   32'(phi_lut),   32'd0);
    checkOutput("rst_rot",   32'(phi_rot),   32'd0);

    // Latency and round-robin order with all configuration at zero.
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    checkOutput("latency_valid_low", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_valid_high", 32'(out_valid), 32'd1);
    checkOutput("first_ch", 32'(out_ch), 32'd0);
    for (int k = 1; k < 8; k++) begin
      getSample();
      checkOutput("rr_ch", 32'(sCh), 32'(k % CH));
      checkOutput("rr_phase", 32'({sR, sLut, sRot}), 32'd0);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // FTW sweep on channel 0: octant steps 0..7 and wraps to 0.
    writeCfg(CFG_SEL_POFF, 2'd0, 32'h0);
    writeCfg(CFG_SEL_FTW,  2'd0, 32'h20000000);
    syncPulse();
    en      = 1'b1;
    nextCh  = 0;
    nextOct = 0;
    repeat (36) begin
      getSample();
      checkStream();
    end

    // Backpressure for 5 cycles: outputs frozen, stream continues cleanly.
    @(negedge clk);
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    frozen    = {out_ch, phi_r, phi_lut, phi_rot};
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid_hold", 32'(out_valid), 32'd1);
      checkOutput("stall_frozen", 32'({out_ch, phi_r, phi_lut, phi_rot}), 32'(frozen));
    end
    out_ready = 1'b1;
    sCh = frozen[18:17];
    sR  = frozen[16:14];
    checkStream();
    repeat (8) begin
      getSample();
      checkStream();
    end

    // Sync during a stall together with a poff write to channel 0.
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    sync     = 1'b1;
    cfg_wr   = 1'b1;
    cfg_sel  = CFG_SEL_POFF;
    cfg_ch   = 2'd0;
    cfg_data = 32'h60000000;
    @(negedge clk);
    sync      = 1'b0;
    cfg_wr    = 1'b0;
    out_ready = 1'b1;
    checkOutput("sync_drop_valid", 32'(out_valid), 32'd0);
    getSample();
    checkOutput("sync_first_ch", 32'(sCh), 32'd0);
    checkOutput("sync_first_phase", 32'({sR, sLut, sRot}), 32'({3'd3, 6'd63, 8'hFF}));
    getSample();
    checkOutput("sync_ch1_phase", 32'({sCh, sR, sLut, sRot}), 32'({2'd1, 3'd7, 6'd63, 8'hFF}));
    getSample();
    getSample();
    getSample();
    checkOutput("sync_ch0_second", 32'({sCh, sR, sLut, sRot}), 32'({2'd0, 3'd4, 6'd0, 8'h00}));

    // Asynchronous reset between edges clears outputs and configuration.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_out", 32'({out_ch, phi_r, phi_lut, phi_rot}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    getSample();
    checkOutput("post_rst_sample", 32'({sCh, sR, sLut, sRot}), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddfs_phase_engine.md
# ddfs_phase_engine

Multi-channel, time-multiplexed phase accumulator with a built-in octant phase transformer for the DDFS datapath. Each channel has its own frequency tuning word and phase offset. One channel is serviced per issued cycle in round-robin order. The accumulated phase is truncated to N bits and split into octant, LUT address and rotation residue, ready for the sine LUT/rotation stage. Output uses a valid/ready handshake so a stalled downstream freezes the scan without losing phase.

## Interface
Parameters:
- ACC_W, 32, accumulator, FTW and phase-offset width.
- N, 17, truncated phase width fed to the transform. Constraint: N < ACC_W.
- L, 6, LUT address width. Constraint: L <= N-4.
- CH, 4, channel count. Must be a power of two, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; issues one channel per cycle when not stalled
- sync  in  1  synchronous clear of all accumulators and the scan pointer
- cfg_wr  in  1  configuration write strobe
- cfg_sel  in  1  0 = FTW, 1 = phase offset
- cfg_ch  in  $clog2(CH)  target channel
- cfg_data  in  ACC_W  write data
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample
- out_ch  out  $clog2(CH)  channel of the current sample
- phi_r  out  3  octant, the top 3 bits of the truncated phase
- phi_lut  out  L  LUT address
- phi_rot  out  N-3-L  rotation residue

## Operation
- Storage per channel: acc[ch], ftw[ch] and poff[ch], each ACC_W wide. Scan pointer sc.
- stall = out_valid & ~out_ready.
- issue = en & ~stall & ~sync.
- Stage 0, on issue:
  - s1_phase <= acc[sc] + poff[sc], modulo 2^ACC_W.
  - acc[sc] <= acc[sc] + ftw[sc], modulo 2^ACC_W.
  - s1_ch <= sc; sc <= sc+1, wrapping CH-1 -> 0.
  - s1_v <= 1.
- Stage 0, on a non-stalled cycle without issue: s1_v <= 0.
- Each sample uses the pre-update accumulator, so a channel's first sample after reset or sync equals poff.
- Stage 1 transform, when not stalled; result registers into the outputs with out_valid <= s1_v:
  - p = s1_phase[ACC_W-1 -: N].
  - oct = p[N-1:N-3].
  - rem = p[N-4:0].
  - f = oct[0] ? ~rem : rem.
  - phi_r = oct; phi_lut = f[N-4 -: L]; phi_rot = f[N-4-L:0].
- Stall: all stages, sc and acc hold. Outputs stay stable until accepted.
- cfg_wr: the write lands at the clock edge. An issue of the same channel in that cycle uses the old value. Writes are accepted during stall and sync.
- sync: all acc <= 0, sc <= 0, s1_v <= 0, out_valid <= 0. It overrides stall, so the pending output is dropped. FTW and poff are kept.

## Timing
- Reset values: all acc, ftw and poff = 0. sc = 0, s1_v = 0, out_valid = 0, out_ch = 0, phi_r = 0, phi_lut = 0, phi_rot = 0.
- Latency: 2 clk from the issue edge to out_valid high, with no stall.
- Throughput: 1 sample/clk. Each channel updates once per CH issued cycles.
- Reset mid-operation clears everything immediately. The first issue after rst_n deasserts services channel 0.
- en low drains the pipe. The last valid sample persists until accepted.

## Configuration
- PT_DITHER_EN defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances on each issue.
  - Its low min(16, ACC_W-N) bits are added to s1_phase before truncation. The carry propagates into p.
  - The accumulator is unaffected.
- Undefined: pure truncation, no LFSR logic.

## Structure
- Shared package ddfs_pkg: the phase-split widths as localparam functions of N/L, the cfg_sel encodings, and the LFSR seed/taps.
- Sub-module phase_fold: purely combinational, p -> {phi_r, phi_lut, phi_rot}. Reused by the single-channel front end.

## Test plan
Defaults N=17, L=6, CH=4, out_ready=1 unless stated.
- Reset then en=1, all cfg 0 -> after 2 clk, out_valid=1; out_ch cycles 0,1,2,3; phi_r=0, phi_lut=0, phi_rot=0.
- poff[0]=0x80000000, ftw 0 -> ch0 samples: phi_r=3'b100, phi_lut=0, phi_rot=8'h00.
- poff[1]=0xE0000000 -> ch1: phi_r=3'b111, phi_lut=63, phi_rot=8'hFF (folded). poff[2]=0xABCD1234 -> ch2: phi_r=3'b101, phi_lut=40, phi_rot=8'h65.
- ftw[0]=0x20000000 -> successive ch0 phi_r = 0,1,2,...,7,0 (wrap).
- out_ready low for 5 clk -> outputs frozen. After release, out_ch order continues with no skipped or repeated sample, and ch0 octant continuity holds.
- sync during a stall with a cfg_wr in the same cycle -> next cycle out_valid=0. Next issue is ch0 with phase = poff[0]. The new cfg value is visible.
